// File: rtl/id_ex_if.sv
// id_ex_if: ID-side decoded instruction inputs and EX-side registered outputs of the ID/EX stage,
// plus the load-use stall flag and stall statistics counter.
interface id_ex_if #(parameter int XLEN = 32, parameter int CNT_W = 16);
  logic valid_i, flush_i;
  logic RegWrite_i, MemToReg_i, MemRead_i, MemWrite_i, ALUSrc_i, Branch_i;
  logic [1:0] ALUOp_i;
  logic [XLEN-1:0] rs1_data_i, rs2_data_i, imm_i;
  logic [4:0] rs1_addr_i, rs2_addr_i, rd_addr_i;
  logic [9:0] funct_i;
  logic valid_o, stall_o;
  logic RegWrite_o, MemToReg_o, MemRead_o, MemWrite_o, ALUSrc_o, Branch_o;
  logic [1:0] ALUOp_o;
  logic [XLEN-1:0] rs1_data_o, rs2_data_o, imm_o;
  logic [4:0] rs1_addr_o, rs2_addr_o, rd_addr_o;
  logic [9:0] funct_o;
  logic [CNT_W-1:0] stall_cnt_o;
  modport master (
    output valid_i, flush_i, RegWrite_i, MemToReg_i, MemRead_i, MemWrite_i, ALUSrc_i, Branch_i,
           ALUOp_i, rs1_data_i, rs2_data_i, imm_i, rs1_addr_i, rs2_addr_i, rd_addr_i, funct_i,
    input  valid_o, stall_o, RegWrite_o, MemToReg_o, MemRead_o, MemWrite_o, ALUSrc_o, Branch_o,
           ALUOp_o, rs1_data_o, rs2_data_o, imm_o, rs1_addr_o, rs2_addr_o, rd_addr_o, funct_o,
           stall_cnt_o
  );
  modport slave (
    input  valid_i, flush_i, RegWrite_i, MemToReg_i, MemRead_i, MemWrite_i, ALUSrc_i, Branch_i,
           ALUOp_i, rs1_data_i, rs2_data_i, imm_i, rs1_addr_i, rs2_addr_i, rd_addr_i, funct_i,
    output valid_o, stall_o, RegWrite_o, MemToReg_o, MemRead_o, MemWrite_o, ALUSrc_o, Branch_o,
           ALUOp_o, rs1_data_o, rs2_data_o, imm_o, rs1_addr_o, rs2_addr_o, rd_addr_o, funct_o,
           stall_cnt_o
  );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use hazard detection, flush/bubble insertion
// and a saturating stall-cycle counter.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input logic    clk_i,
  input logic    rst_i,
  id_ex_if.slave b
);
  localparam int W = 3 * XLEN + 34;
  logic hazard, stall, load;
  logic [W-1:0] pipe_d, pipe_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  // valid_i gates everything, so undefined fields of an empty ID slot never reach EX
  always_comb begin
    hazard = b.valid_o & b.MemRead_o & (b.rd_addr_o != 5'd0) & b.valid_i &
             ((b.rd_addr_o == b.rs1_addr_i) | (b.rd_addr_o == b.rs2_addr_i));
    stall  = hazard & ~b.flush_i;
    load   = b.valid_i & ~b.flush_i & ~hazard;
    pipe_d = load ? {1'b1, b.RegWrite_i, b.MemToReg_i, b.MemRead_i, b.MemWrite_i, b.ALUSrc_i,
                     b.Branch_i, b.ALUOp_i, b.rs1_data_i, b.rs2_data_i, b.imm_i,
                     b.rs1_addr_i, b.rs2_addr_i, b.rd_addr_i, b.funct_i} : '0;
    cnt_d  = (stall && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pipe_q <= '0;
      cnt_q  <= '0;
    end else begin
      pipe_q <= pipe_d;
      cnt_q  <= cnt_d;
    end
  end
  assign {b.valid_o, b.RegWrite_o, b.MemToReg_o, b.MemRead_o, b.MemWrite_o, b.ALUSrc_o,
          b.Branch_o, b.ALUOp_o, b.rs1_data_o, b.rs2_data_o, b.imm_o,
          b.rs1_addr_o, b.rs2_addr_o, b.rd_addr_o, b.funct_o} = pipe_q;
  assign b.stall_o     = stall;
  assign b.stall_cnt_o = cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: randomized and directed checks of id_ex_stage against an instruction-level
// model; a second instance with a 2-bit counter exercises saturation.
module tb_id_ex_stage;
  typedef struct packed {
    logic v, rw, m2r, mr, mw, as, br;
    logic [1:0] op;
    logic [31:0] d1, d2, imm;
    logic [4:0] a1, a2, rd;
    logic [9:0] fn;
  } rec_t;
  typedef struct packed {
    logic flush;
    rec_t r;
  } in_t;

  logic clk_i, rst_i;
  in_t in, x;
  rec_t got16, got2, ex_m;
  int cnt_m, n_tests, n_fail;
  logic s;

  id_ex_if #(.XLEN(32), .CNT_W(16)) i16 ();
  id_ex_if #(.XLEN(32), .CNT_W(2)) i2 ();

  id_ex_stage #(.XLEN(32), .CNT_W(16)) u16 (.clk_i(clk_i), .rst_i(rst_i), .b(i16.slave));
  id_ex_stage #(.XLEN(32), .CNT_W(2)) u2 (.clk_i(clk_i), .rst_i(rst_i), .b(i2.slave));

  assign {i16.flush_i, i16.valid_i, i16.RegWrite_i, i16.MemToReg_i, i16.MemRead_i, i16.MemWrite_i,
          i16.ALUSrc_i, i16.Branch_i, i16.ALUOp_i, i16.rs1_data_i, i16.rs2_data_i, i16.imm_i,
          i16.rs1_addr_i, i16.rs2_addr_i, i16.rd_addr_i, i16.funct_i} = in;
  assign {i2.flush_i, i2.valid_i, i2.RegWrite_i, i2.MemToReg_i, i2.MemRead_i, i2.MemWrite_i,
          i2.ALUSrc_i, i2.Branch_i, i2.ALUOp_i, i2.rs1_data_i, i2.rs2_data_i, i2.imm_i,
          i2.rs1_addr_i, i2.rs2_addr_i, i2.rd_addr_i, i2.funct_i} = in;
  assign got16 = {i16.valid_o, i16.RegWrite_o, i16.MemToReg_o, i16.MemRead_o, i16.MemWrite_o,
                  i16.ALUSrc_o, i16.Branch_o, i16.ALUOp_o, i16.rs1_data_o, i16.rs2_data_o,
                  i16.imm_o, i16.rs1_addr_o, i16.rs2_addr_o, i16.rd_addr_o, i16.funct_o};
  assign got2 = {i2.valid_o, i2.RegWrite_o, i2.MemToReg_o, i2.MemRead_o, i2.MemWrite_o,
                 i2.ALUSrc_o, i2.Branch_o, i2.ALUOp_o, i2.rs1_data_o, i2.rs2_data_o,
                 i2.imm_o, i2.rs1_addr_o, i2.rs2_addr_o, i2.rd_addr_o, i2.funct_o};

  initial begin
    clk_i = 0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic chk(input string nm, input logic [159:0] got, input logic [159:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // a load in EX whose nonzero destination is read by the valid instruction in ID
  function automatic logic haz(input rec_t e, input in_t y);
    return e.v && e.mr && e.rd != 5'd0 && y.r.v && (e.rd == y.r.a1 || e.rd == y.r.a2);
  endfunction

  function automatic int sat(input int c, input int mx);
    return c > mx ? mx : c;
  endfunction

  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_m  <= '0;
      cnt_m <= 0;
    end else if (in.flush) ex_m <= '0;
    else if (haz(ex_m, in)) begin
      ex_m  <= '0;
      cnt_m <= cnt_m + 1;
    end else ex_m <= in.r.v ? in.r : '0;
  end

  always @(negedge clk_i) begin
    chk("stall16", 160'(i16.stall_o), 160'(rst_i && !in.flush && haz(ex_m, in)));
    chk("stall2", 160'(i2.stall_o), 160'(rst_i && !in.flush && haz(ex_m, in)));
    chk("ex16", 160'(got16), 160'(ex_m));
    chk("ex2", 160'(got2), 160'(ex_m));
    chk("cnt16", 160'(i16.stall_cnt_o), 160'(sat(cnt_m, 65535)));
    chk("cnt2", 160'(i2.stall_cnt_o), 160'(sat(cnt_m, 3)));
  end

  task automatic adv();
    @(posedge clk_i);
    #1;
  endtask

  function automatic in_t rnd();
    in_t y;
    y = '0;
    y.flush = ($urandom_range(7) == 0);
    y.r.v = ($urandom_range(3) != 0);
    {y.r.rw, y.r.m2r, y.r.mw, y.r.as, y.r.br} = 5'($urandom);
    y.r.mr = ($urandom_range(1) == 0);
    y.r.op = 2'($urandom);
    y.r.d1 = $urandom;
    y.r.d2 = $urandom;
    y.r.imm = $urandom;
    y.r.a1 = 5'($urandom_range(3));
    y.r.a2 = 5'($urandom_range(3));
    y.r.rd = 5'($urandom_range(3));
    y.r.fn = 10'($urandom);
    return y;
  endfunction

  initial begin
    n_tests = 0;
    n_fail = 0;
    in = '0;
    rst_i = 1;
    #1 rst_i = 0;
    adv();
    adv();
    rst_i = 1;
    // plain load of an ALU instruction
    x = '0; x.r.v = 1; x.r.rw = 1; x.r.op = 2'b10; x.r.d1 = 32'h1234; x.r.rd = 5'd5;
    in = x;
    adv();
    chk("load_rw", 160'(i16.RegWrite_o), 160'(1));
    chk("load_op", 160'(i16.ALUOp_o), 160'(2'b10));
    chk("load_d1", 160'(i16.rs1_data_o), 160'(32'h1234));
    chk("load_rd", 160'(i16.rd_addr_o), 160'(5));
    chk("load_v", 160'(i16.valid_o), 160'(1));
    // load-use on rs2
    x = '0; x.r.v = 1; x.r.mr = 1; x.r.rd = 5'd7; x.r.a1 = 5'd1; x.r.a2 = 5'd2;
    in = x;
    adv();
    x = '0; x.r.v = 1; x.r.rw = 1; x.r.a1 = 5'd3; x.r.a2 = 5'd7; x.r.rd = 5'd8;
    in = x;
    #1 chk("lu_stall", 160'(i16.stall_o), 160'(1));
    adv();
    chk("lu_bubble_v", 160'(i16.valid_o), 160'(0));
    chk("lu_bubble_rw", 160'(i16.RegWrite_o), 160'(0));
    chk("lu_cnt", 160'(i16.stall_cnt_o), 160'(1));
    chk("lu_nostall", 160'(i16.stall_o), 160'(0));
    adv();
    chk("lu_reload", 160'(i16.rd_addr_o), 160'(8));
    // x0 destination never stalls
    x = '0; x.r.v = 1; x.r.mr = 1; x.r.rd = 5'd0;
    in = x;
    adv();
    x = '0; x.r.v = 1; x.r.rw = 1; x.r.a1 = 5'd0; x.r.rd = 5'd9;
    in = x;
    #1 chk("x0_stall", 160'(i16.stall_o), 160'(0));
    adv();
    chk("x0_load", 160'(i16.rd_addr_o), 160'(9));
    // flush beats hazard
    x = '0; x.r.v = 1; x.r.mr = 1; x.r.rd = 5'd7;
    in = x;
    adv();
    x = '0; x.flush = 1; x.r.v = 1; x.r.a1 = 5'd7;
    in = x;
    #1 chk("fl_stall", 160'(i16.stall_o), 160'(0));
    adv();
    chk("fl_v", 160'(i16.valid_o), 160'(0));
    chk("fl_cnt", 160'(i16.stall_cnt_o), 160'(1));
    // self-dependent load held in ID: load, stall, load, stall ... five stalls
    x = '0; x.r.v = 1; x.r.mr = 1; x.r.rd = 5'd4; x.r.a1 = 5'd4;
    in = x;
    for (int i = 0; i < 10; i++) adv();
    chk("sat_cnt16", 160'(i16.stall_cnt_o), 160'(6));
    chk("sat_cnt2", 160'(i2.stall_cnt_o), 160'(3));
    // empty slot with undefined fields
    in = 'x; in.flush = 0; in.r.v = 0;
    adv();
    chk("xin_out", 160'(got16), 160'(0));
    // asynchronous reset between edges
    x = '0; x.r.v = 1; x.r.rw = 1; x.r.rd = 5'd3; x.r.d2 = 32'hdead;
    in = x;
    adv();
    chk("ar_pre_v", 160'(i16.valid_o), 160'(1));
    #2 rst_i = 0;
    #1 chk("ar_out", 160'(got16), 160'(0));
    chk("ar_cnt", 160'(i16.stall_cnt_o), 160'(0));
    chk("ar_stall", 160'(i16.stall_o), 160'(0));
    adv();
    rst_i = 1;
    // randomized traffic; a stalled instruction is re-presented by ID
    s = 0;
    for (int c = 0; c < 3000; c++) begin
      x = rnd();
      if (s) x.r = in.r;
      in = x;
      rst_i = ($urandom_range(199) != 0);
      s = rst_i && !in.flush && haz(ex_m, in);
      adv();
    end
    rst_i = 1;
    in = '0;
    adv();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
